// File: rtl/cr_prefix_fe_ser.sv
// Purpose: snapshots 256 prefix feature counters and streams them as 32 64-bit words (optional checksum word: CR_PREFIX_FE_SER_CHKSUM_EN).
// Latency: request at edge t gives word 0 valid from cycle t+1; one word per cycle while ser_tready stays high.
// Backpressure: valid/ready; word, index and last hold while stalled; requests while busy are dropped and flagged.
module cr_prefix_fe_ser #(
  parameter int N_PREFIX_FEATURE_CTR = 64,
  parameter int SER_DWIDTH           = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_PREFIX_FEATURE_CTR*8-1:0] fe_ctr_1,
  input  logic [N_PREFIX_FEATURE_CTR*8-1:0] fe_ctr_2,
  input  logic [N_PREFIX_FEATURE_CTR*8-1:0] fe_ctr_3,
  input  logic [N_PREFIX_FEATURE_CTR*8-1:0] fe_ctr_4,
  input  logic                              ser_snap_req,
  output logic                              ser_tvalid,
  input  logic                              ser_tready,
  output logic [SER_DWIDTH-1:0]             ser_tdata,
  output logic                              ser_tlast,
  output logic [5:0]                        ser_tidx,
  output logic                              ser_busy,
  output logic                              ser_snap_drop
);

  localparam int SNAP_W  = 4 * N_PREFIX_FEATURE_CTR * 8;
  localparam int N_WORDS = SNAP_W / SER_DWIDTH;
  localparam int IDX_W   = $clog2(N_WORDS);
`ifdef CR_PREFIX_FE_SER_CHKSUM_EN
  // Checksum word rides after the last counter word.
  localparam logic [5:0] LAST_IDX = 6'(N_WORDS);
`else
  localparam logic [5:0] LAST_IDX = 6'(N_WORDS - 1);
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                 state;
  logic [SNAP_W-1:0]      snap;
  logic [5:0]             nxt_idx;
  logic [SER_DWIDTH-1:0]  nxt_word;

`ifdef CR_PREFIX_FE_SER_CHKSUM_EN
  logic [15:0] acc;
  logic [15:0] acc_nxt;

  // Sum of the byte counters carried by one output word.
  function automatic logic [15:0] byte_sum(input logic [SER_DWIDTH-1:0] w);
    logic [15:0] s;
    s = '0;
    for (int b = 0; b < SER_DWIDTH / 8; b++) begin
      s = s + 16'(w[b*8 +: 8]);
    end
    return s;
  endfunction

  // Running checksum including the word currently being presented.
  always_comb begin
    acc_nxt = acc + byte_sum(ser_tdata);
  end
`endif

  // Index and snapshot word of the word following the current one.
  always_comb begin
    nxt_idx  = ser_tidx + 6'd1;
    nxt_word = snap[nxt_idx[IDX_W-1:0]*SER_DWIDTH +: SER_DWIDTH];
  end

  // Snapshot capture: only on the edge that starts a frame, never reset.
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_IDLE) && ser_snap_req) begin
      snap <= {fe_ctr_4, fe_ctr_3, fe_ctr_2, fe_ctr_1};
    end
  end

  // Frame FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ser_tvalid    <= 1'b0;
      ser_busy      <= 1'b0;
      ser_tlast     <= 1'b0;
      ser_tidx      <= '0;
      ser_tdata     <= '0;
      ser_snap_drop <= 1'b0;
`ifdef CR_PREFIX_FE_SER_CHKSUM_EN
      acc           <= '0;
`endif
    end else begin
      ser_snap_drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ser_snap_req) begin
            state      <= S_SEND;
            ser_tvalid <= 1'b1;
            ser_busy   <= 1'b1;
            ser_tlast  <= 1'b0;
            ser_tidx   <= '0;
            // Word 0 comes straight from the inputs being captured this edge.
            ser_tdata  <= fe_ctr_1[SER_DWIDTH-1:0];
`ifdef CR_PREFIX_FE_SER_CHKSUM_EN
            acc        <= '0;
`endif
          end
        end
        S_SEND: begin
          ser_snap_drop <= ser_snap_req;
          if (ser_tready) begin
            if (ser_tlast) begin
              state      <= S_IDLE;
              ser_tvalid <= 1'b0;
              ser_busy   <= 1'b0;
              ser_tlast  <= 1'b0;
              ser_tidx   <= '0;
              ser_tdata  <= '0;
            end else begin
              ser_tidx  <= nxt_idx;
              ser_tlast <= (nxt_idx == LAST_IDX);
`ifdef CR_PREFIX_FE_SER_CHKSUM_EN
              acc <= acc_nxt;
              if (nxt_idx == 6'(N_WORDS)) begin
                ser_tdata <= SER_DWIDTH'(acc_nxt);
              end else begin
                ser_tdata <= nxt_word;
              end
`else
              ser_tdata <= nxt_word;
`endif
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cr_prefix_fe_ser.md
# cr_prefix_fe_ser

Counter snapshot serializer for the prefix engine. Sits downstream of the prefix feature extractor and reads its four packed 64×8-bit feature counter vectors. On request, it captures all 256 counters in one cycle and streams them out as 64-bit words over a valid/ready interface to the prefix TLV builder. The feature extractor can reload its counters as soon as the capture has happened.

## Interface
Parameters:
- N_PREFIX_FEATURE_CTR, 64, counters per block; four blocks give 256 counters total.
- SER_DWIDTH, 64, output word width in bits; each word carries 8 counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Synchronous, active-low; sampled on the rising edge of clk.
- fe_ctr_1  in  512  counters 0..63; counter i is in bits [8i+7:8i].
- fe_ctr_2  in  512  counters 64..127, same packing.
- fe_ctr_3  in  512  counters 128..191, same packing.
- fe_ctr_4  in  512  counters 192..255, same packing.
- ser_snap_req  in  1  single-cycle capture request.
- ser_tvalid  out  1  output word valid.
- ser_tready  in  1  downstream ready.
- ser_tdata  out  64  output word.
- ser_tlast  out  1  marks the final word of a frame.
- ser_tidx  out  6  index of the current word.
- ser_busy  out  1  high while a frame is in flight.
- ser_snap_drop  out  1  one-cycle pulse: a request arrived while busy and was discarded.

## Operation
- States:
  - IDLE: ser_busy=0, ser_tvalid=0.
  - SEND: ser_busy=1, ser_tvalid=1.
- IDLE→SEND:
  - Trigger: ser_snap_req=1 at an edge while in IDLE.
  - At that edge, all 2048 input bits are registered into the snapshot.
  - The word index is cleared to 0 and the checksum accumulator to 0.
- SEND:
  - ser_tdata = snapshot counters 8w..8w+7, where w = ser_tidx.
  - Counter 8w sits in bits [7:0], counter 8w+7 in bits [63:56].
  - Word w comes from block w/8, slice (w%8)*64 +: 64.
- Handshake:
  - A transfer occurs on an edge where ser_tvalid && ser_tready.
  - On a transfer, the index increments by 1 and the 8 bytes are added to a 16-bit checksum accumulator.
  - With ser_tvalid high and no transfer, ser_tdata, ser_tidx and ser_tlast hold stable.
  - ser_tvalid never drops without a transfer, except on reset.
- Frame end:
  - ser_tlast=1 only on the last word (index 31, or 32 with the checksum word enabled).
  - A transfer on the last word returns the block to IDLE.
- Request while busy:
  - ser_snap_req in SEND, including the cycle of the final transfer, is discarded.
  - The snapshot is not modified.
  - ser_snap_drop pulses high on the following cycle.
- The live fe_ctr_* inputs are ignored outside the capture edge.
- Reset:
  - rst_n=0 sampled at any edge forces IDLE and clears the index, accumulator and ser_snap_drop.
  - This applies mid-frame too: the partial frame is abandoned with no ser_tlast.
  - The snapshot register is not reset; its contents are don't-care until the next capture.
- Output reset values: ser_tvalid=0, ser_tlast=0, ser_busy=0, ser_snap_drop=0, ser_tidx=0, ser_tdata=0.
  - ser_tdata is forced to 0 whenever in IDLE.

## Timing
- Request at edge t → ser_tvalid=1 with index 0 from cycle t+1. Capture latency is 1 cycle.
- With ser_tready held high: 32 words on consecutive cycles t+1..t+32 (33 words with the checksum word), ser_busy=0 from t+33.
- The earliest next accepted request is at the edge where ser_busy is already 0. This gives one idle cycle minimum between frames.
- All outputs are registered; no combinational path from ser_tready to any output other than through state.
- Checksum arithmetic:
  - Unsigned 16-bit sum of all 256 counters; the maximum is 65280, so it never wraps.
  - Accumulated one word per transfer; no wide adder tree.

## Configuration
- CR_PREFIX_FE_SER_CHKSUM_EN defined:
  - After word 31, a 33rd word (index 32) is sent with ser_tdata = {48'b0, checksum}.
  - The checksum covers words 0..31 and is complete at the edge word 31 transfers.
  - ser_tlast moves to index 32.
- Not defined:
  - The frame is 32 words with ser_tlast at index 31.
  - No accumulator logic is built, and ser_tidx never exceeds 31.

## Test plan
- Counter k = k mod 256, single request, ser_tready=1 → 32 words on consecutive cycles, word 0 = 0x0706050403020100, word 31 = 0xFFFEFDFCFBFAF9F8, ser_tlast only at index 31. With the macro defined: word 32 = 0x7F80 and ser_tlast at index 32.
- Same data, ser_tready toggled 1-0-0-1 pseudo-randomly → every word is held stable while stalled, the sequence is identical, and there are no duplicate or missing indices.
- fe_ctr_* changed to all 0xFF the cycle after the request → output still matches the captured pattern.
- Second ser_snap_req at word 10, then one in the final-transfer cycle → both are discarded, ser_snap_drop pulses twice, and the frame completes unchanged.
- rst_n=0 for one cycle at word 15 → next cycle ser_tvalid=0, ser_busy=0, ser_tidx=0. A new request then produces a full frame starting at index 0.
- All counters 0xFF with the macro defined → checksum word = 0x000000000000FF00.
